// File: rtl/rv32i_types.sv
// rv32i_types: shared rv32i pipeline types.
// Provides the opcode enum and the control word carried down the pipeline.
// It also holds the port-state enums and the access classifier used by
// mem_stall_ctrl.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic        load_regfile;
  } rv32i_control_word;

  // Instruction-port response capture
  typedef enum logic [1:0] {
    I_WAIT = 2'd0,
    I_DONE = 2'd1,
    I_DROP = 2'd2
  } imem_state_t;

  // Data-port response capture
  typedef enum logic {
    D_IDLE = 1'b0,
    D_DONE = 1'b1
  } dmem_state_t;

  // True when the instruction in EX_MEM touches data memory
  function automatic logic is_mem_access(input rv32i_opcode op);
    return (op == op_load) || (op == op_store);
  endfunction

endpackage

// File: rtl/mem_stall_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst (async, active-high), inc (count this cycle), clr (sync
// clear, wins over inc), count (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count register: clear, saturating increment, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (clr) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mem_stall_ctrl.sv
// mem_stall_ctrl: pipeline stall controller for split I/D memory ports.
// Each cycle it decides which pipeline registers and the PC may load.
// Both ports have a small FSM that captures a response which arrives
// while the other port is still busy, so that the response is not lost.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_ctrl_word_i   control word in EX_MEM (load/store => data access)
//   imem_resp_i       I-cache response pulse
//   dmem_resp_i       D-cache response pulse
//   flush_i           redirect from branch resolution
//   ld_o              per-pipeline-register load enable (0=IF_ID .. MEM_WB)
//   pc_ld_o           PC load enable
//   bubble_o          inject NOP into ID_EX
//   imem_read_o       issue/hold I-cache read
//   imem_stall_o      stall caused by I-port
//   dmem_stall_o      stall caused by D-port
//   stall_cycles_o    saturating count of non-advancing, non-flush cycles
module mem_stall_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_REGS    = 4,
  parameter int SPLIT_STALL = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  rv32i_control_word     mem_ctrl_word_i,
  input  logic                  imem_resp_i,
  input  logic                  dmem_resp_i,
  input  logic                  flush_i,
  output logic [NUM_REGS-1:0]   ld_o,
  output logic                  pc_ld_o,
  output logic                  bubble_o,
  output logic                  imem_read_o,
  output logic                  imem_stall_o,
  output logic                  dmem_stall_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  imem_state_t i_state, i_next;
  dmem_state_t d_state, d_next;
  logic        mem_access;
  logic        i_ok;
  logic        d_ok;
  logic        advance;
  logic        stall_inc;
  logic        unused_cw;

  // Only the opcode matters here; the rest of the word is carried for others
  assign unused_cw = ^{mem_ctrl_word_i.funct3, mem_ctrl_word_i.load_regfile};

  // Port satisfaction terms and the global advance decision
  always_comb begin
    mem_access = is_mem_access(mem_ctrl_word_i.opcode);
    i_ok       = ((i_state == I_WAIT) && imem_resp_i && !flush_i) || (i_state == I_DONE);
    d_ok       = !mem_access || dmem_resp_i || (d_state == D_DONE);
    advance    = i_ok && d_ok;
    stall_inc  = !advance && !flush_i;
  end

  // Port state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_state <= I_WAIT;
      d_state <= D_IDLE;
    end else begin
      i_state <= i_next;
      d_state <= d_next;
    end
  end

  // I-port next state: a flush beats a same-cycle response (that fetch is stale)
  always_comb begin
    i_next = i_state;
    case (i_state)
      I_WAIT: begin
        if (flush_i) begin
          i_next = imem_resp_i ? I_WAIT : I_DROP;
        end else if (imem_resp_i) begin
          i_next = advance ? I_WAIT : I_DONE;
        end else begin
          i_next = I_WAIT;
        end
      end
      I_DONE: begin
        if (advance || flush_i) begin
          i_next = I_WAIT;
        end else begin
          i_next = I_DONE;
        end
      end
      I_DROP: begin
        if (imem_resp_i) begin
          i_next = I_WAIT;
        end else begin
          i_next = I_DROP;
        end
      end
      default: i_next = I_WAIT;
    endcase
  end

  // D-port next state: a captured response is meaningless once EX_MEM holds no access
  always_comb begin
    d_next = d_state;
    if (!mem_access) begin
      d_next = D_IDLE;
    end else begin
      case (d_state)
        D_IDLE:  d_next = (dmem_resp_i && !advance) ? D_DONE : D_IDLE;
        D_DONE:  d_next = advance ? D_IDLE : D_DONE;
        default: d_next = D_IDLE;
      endcase
    end
  end

  // Load enables; the D-stall dominates both the I-stall and a flush
  always_comb begin
    ld_o         = {NUM_REGS{1'b0}};
    pc_ld_o      = 1'b0;
    bubble_o     = 1'b0;
    dmem_stall_o = !d_ok;
    imem_stall_o = !i_ok && !flush_i;
    imem_read_o  = !rst && (i_state == I_WAIT);
    if (rst) begin
      ld_o     = {NUM_REGS{1'b0}};
      pc_ld_o  = 1'b0;
      bubble_o = 1'b0;
    end else if (!d_ok) begin
      ld_o     = {NUM_REGS{1'b0}};
      pc_ld_o  = 1'b0;
      bubble_o = 1'b0;
    end else if (flush_i || advance) begin
      // On a flush the pipe keeps moving; IF_ID is cleared by the flush path
      ld_o     = {NUM_REGS{1'b1}};
      pc_ld_o  = 1'b1;
      bubble_o = 1'b0;
    end else if (SPLIT_STALL != 0) begin
      // I-only stall: hold IF_ID, drain the back stages behind a bubble
      ld_o     = {NUM_REGS{1'b1}};
      ld_o[0]  = 1'b0;
      pc_ld_o  = 1'b0;
      bubble_o = 1'b1;
    end else begin
      ld_o     = {NUM_REGS{1'b0}};
      pc_ld_o  = 1'b0;
      bubble_o = 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_cycles_o)
  );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed, table-driven bench for mem_stall_ctrl. Two instances share the
// stimulus: dut (SPLIT_STALL=1) and dut_ns (SPLIT_STALL=0), with separate
// resets so one can be reset while the other saturates its counter.
module tb_mem_stall_ctrl;
  import rv32i_types::*;

  logic              clk;
  logic              rst;
  logic              rst2;
  rv32i_control_word cw;
  logic              iresp;
  logic              dresp;
  logic              flush;

  logic [3:0]  ld,  ld_n;
  logic        pc,  pc_n;
  logic        bub, bub_n;
  logic        rd,  rd_n;
  logic        is,  is_n;
  logic        ds,  ds_n;
  logic [15:0] cnt, cnt_n;

  int checks = 0;
  int errors = 0;

  mem_stall_ctrl #(.NUM_REGS(4), .SPLIT_STALL(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mem_ctrl_word_i(cw), .imem_resp_i(iresp),
    .dmem_resp_i(dresp), .flush_i(flush), .ld_o(ld), .pc_ld_o(pc),
    .bubble_o(bub), .imem_read_o(rd), .imem_stall_o(is), .dmem_stall_o(ds),
    .stall_cycles_o(cnt)
  );

  mem_stall_ctrl #(.NUM_REGS(4), .SPLIT_STALL(0), .CNT_W(16)) dut_ns (
    .clk(clk), .rst(rst2), .mem_ctrl_word_i(cw), .imem_resp_i(iresp),
    .dmem_resp_i(dresp), .flush_i(flush), .ld_o(ld_n), .pc_ld_o(pc_n),
    .bubble_o(bub_n), .imem_read_o(rd_n), .imem_stall_o(is_n), .dmem_stall_o(ds_n),
    .stall_cycles_o(cnt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus must never present a response to a port that already holds one
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(dut.i_state == I_DONE && iresp)) else $error("imem response while I_DONE");
      assert (!(dut.d_state == D_DONE && dresp)) else $error("dmem response while D_DONE");
    end
  end

  typedef struct {
    rv32i_opcode op;
    logic        ir, dr, fl;
    logic [3:0]  e_ld;
    logic        e_pc, e_bub, e_rd, e_ds, e_is;
    logic [15:0] e_cnt;
    logic [3:0]  e_ldn;
    logic        e_bubn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(rv32i_opcode op, logic ir, logic dr, logic fl,
                              logic [3:0] l, logic p, logic b, logic r, logic d, logic i,
                              logic [15:0] c, logic [3:0] ln, logic bn);
    vec_t v;
    v.op = op; v.ir = ir; v.dr = dr; v.fl = fl;
    v.e_ld = l; v.e_pc = p; v.e_bub = b; v.e_rd = r; v.e_ds = d; v.e_is = i;
    v.e_cnt = c; v.e_ldn = ln; v.e_bubn = bn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // A: no data access, fetch every cycle
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(op_imm,   1'b1,1'b0,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd0,  4'b1111,1'b0));
    // B: load; I responds first (captured), D three cycles later
    vecs.push_back(mk(op_load,  1'b1,1'b0,1'b0, 4'b0000,1'b0,1'b0,1'b1,1'b1,1'b0, 16'd0,  4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b0,1'b0,1'b0, 4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0, 16'd1,  4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b0,1'b0,1'b0, 4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0, 16'd2,  4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b0,1'b1,1'b0, 4'b1111,1'b1,1'b0,1'b0,1'b0,1'b0, 16'd3,  4'b1111,1'b0));
    // C: I-miss for 3 cycles with no data access
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b1,1'b0,1'b1, 16'd3,  4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b1,1'b0,1'b1, 16'd4,  4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b1,1'b0,1'b1, 16'd5,  4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b1,1'b0,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd6,  4'b1111,1'b0));
    // D: flush in I_WAIT, stale response 2 cycles later is dropped
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b1, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd6,  4'b1111,1'b0));
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b0,1'b0,1'b1, 16'd6,  4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b1,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b0,1'b0,1'b1, 16'd7,  4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b1,1'b0,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd8,  4'b1111,1'b0));
    // E: store with both responses together, then prove no DONE was entered
    vecs.push_back(mk(op_store, 1'b1,1'b1,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd8,  4'b1111,1'b0));
    vecs.push_back(mk(op_store, 1'b0,1'b0,1'b0, 4'b0000,1'b0,1'b0,1'b1,1'b1,1'b1, 16'd8,  4'b0000,1'b0));
    vecs.push_back(mk(op_store, 1'b1,1'b1,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd9,  4'b1111,1'b0));
    // F: D captured, then a non-access cycle forces D_IDLE, next load stalls again
    vecs.push_back(mk(op_load,  1'b0,1'b1,1'b0, 4'b1110,1'b0,1'b1,1'b1,1'b0,1'b1, 16'd9,  4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b1,1'b0,1'b1, 16'd10, 4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b1,1'b0,1'b0, 4'b0000,1'b0,1'b0,1'b1,1'b1,1'b0, 16'd11, 4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b0,1'b1,1'b0, 4'b1111,1'b1,1'b0,1'b0,1'b0,1'b0, 16'd12, 4'b1111,1'b0));
    // G: D-stall beats flush; drop, then D captured, then release
    vecs.push_back(mk(op_load,  1'b0,1'b0,1'b1, 4'b0000,1'b0,1'b0,1'b1,1'b1,1'b0, 16'd12, 4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b1,1'b1,1'b0, 4'b1110,1'b0,1'b1,1'b0,1'b0,1'b1, 16'd12, 4'b0000,1'b0));
    vecs.push_back(mk(op_load,  1'b1,1'b0,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd13, 4'b1111,1'b0));
    // H: flush with a same-cycle response stays in I_WAIT
    vecs.push_back(mk(op_imm,   1'b1,1'b0,1'b1, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd13, 4'b1111,1'b0));
    vecs.push_back(mk(op_imm,   1'b0,1'b0,1'b0, 4'b1110,1'b0,1'b1,1'b1,1'b0,1'b1, 16'd13, 4'b0000,1'b0));
    vecs.push_back(mk(op_imm,   1'b1,1'b0,1'b0, 4'b1111,1'b1,1'b0,1'b1,1'b0,1'b0, 16'd14, 4'b1111,1'b0));

    // Reset state, with a response present to show it is ignored
    rst = 1'b1; rst2 = 1'b1;
    cw = '0; cw.opcode = op_imm;
    iresp = 1'b1; dresp = 1'b0; flush = 1'b0;
    #2;
    check("rst ld", 32'(ld), 32'h0);
    check("rst pc_ld", 32'(pc), 32'h0);
    check("rst bubble", 32'(bub), 32'h0);
    check("rst imem_read", 32'(rd), 32'h0);
    @(posedge clk); #1;
    check("rst cnt", 32'(cnt), 32'h0);
    check("rst ld held", 32'(ld), 32'h0);
    @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      cw.opcode = vecs[i].op;
      iresp     = vecs[i].ir;
      dresp     = vecs[i].dr;
      flush     = vecs[i].fl;
      #3;
      check($sformatf("v%0d ld", i),          32'(ld),    32'(vecs[i].e_ld));
      check($sformatf("v%0d pc_ld", i),       32'(pc),    32'(vecs[i].e_pc));
      check($sformatf("v%0d bubble", i),      32'(bub),   32'(vecs[i].e_bub));
      check($sformatf("v%0d imem_read", i),   32'(rd),    32'(vecs[i].e_rd));
      check($sformatf("v%0d dmem_stall", i),  32'(ds),    32'(vecs[i].e_ds));
      check($sformatf("v%0d imem_stall", i),  32'(is),    32'(vecs[i].e_is));
      check($sformatf("v%0d stall_cnt", i),   32'(cnt),   32'(vecs[i].e_cnt));
      check($sformatf("v%0d ld_nosplit", i),  32'(ld_n),  32'(vecs[i].e_ldn));
      check($sformatf("v%0d bub_nosplit", i), 32'(bub_n), 32'(vecs[i].e_bubn));
      @(posedge clk); #1;
    end

    // Long D-stall up to 0xFFFE on both instances
    cw.opcode = op_load; iresp = 1'b0; dresp = 1'b0; flush = 1'b0;
    for (int n = 0; n < (16'hFFFE - 14); n++) @(posedge clk);
    #3;
    check("cnt at fffe", 32'(cnt), 32'hFFFE);
    check("cnt_ns at fffe", 32'(cnt_n), 32'hFFFE);
    check("dstall before rst", 32'(ds), 32'h1);

    // Asynchronous reset mid D-stall on dut only
    rst = 1'b1;
    #1;
    check("midrst ld", 32'(ld), 32'h0);
    check("midrst pc_ld", 32'(pc), 32'h0);
    check("midrst bubble", 32'(bub), 32'h0);
    check("midrst imem_read", 32'(rd), 32'h0);
    check("midrst cnt", 32'(cnt), 32'h0);
    @(posedge clk); #1;
    check("cnt_ns saturate", 32'(cnt_n), 32'hFFFF);
    check("midrst cnt held", 32'(cnt), 32'h0);
    @(posedge clk); #1;
    check("cnt_ns no wrap", 32'(cnt_n), 32'hFFFF);
    @(posedge clk); #1;
    check("cnt_ns still sat", 32'(cnt_n), 32'hFFFF);
    rst = 1'b0;
    #1;
    check("post rst imem_read", 32'(rd), 32'h1);
    check("post rst dstall", 32'(ds), 32'h1);
    check("post rst cnt", 32'(cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
Parametrised pipeline stall controller for the rv32i core with split I/D memory ports. It decides, each cycle, which pipeline registers and the PC may load. Successor to the single-flag stall unit, with these additions:
- per-port response capture FSMs, so a response that arrives while the other port is still busy is not lost;
- optional split stall, so back stages drain with a bubble on an I-miss;
- flush-aware dropping of stale fetches;
- a saturating stall-cycle counter.

Parameters:
NUM_REGS, 4, number of pipeline registers; index 0=IF_ID, 1=ID_EX, 2=EX_MEM, 3=MEM_WB
SPLIT_STALL, 1, 1: an I-only stall holds reg 0 and lets regs 1..NUM_REGS-1 advance with a bubble; 0: any stall holds all regs
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
mem_ctrl_word_i  in  rv32i_control_word  control word in EX_MEM; opcode op_load or op_store marks a data access
imem_resp_i  in  1  I-cache response pulse, 1 cycle
dmem_resp_i  in  1  D-cache response pulse, 1 cycle
flush_i  in  1  redirect from branch resolution
ld_o  out  NUM_REGS  per-register load enable, 1 = load
pc_ld_o  out  1  PC load enable
bubble_o  out  1  load NOP into ID_EX this cycle
imem_read_o  out  1  issue/hold I-cache read
imem_stall_o  out  1  stall caused by I-port
dmem_stall_o  out  1  stall caused by D-port
stall_cycles_o  out  CNT_W  saturating count of cycles with advance=0

Behaviour:
- mem_access = opcode in {op_load, op_store}.
- I-port FSM states: I_WAIT (reset), I_DONE, I_DROP.
  - I_WAIT: resp & advance -> I_WAIT (next fetch); resp & ~advance -> I_DONE; flush & ~resp -> I_DROP; flush & resp -> I_WAIT (response discarded).
  - I_DONE: advance | flush -> I_WAIT; else stay.
  - I_DROP: resp -> I_WAIT (stale response discarded); else stay.
- D-port FSM states: D_IDLE (reset), D_DONE.
  - D_IDLE: mem_access & resp & ~advance -> D_DONE.
  - D_DONE: advance -> D_IDLE.
  - D_DONE is forced to D_IDLE if mem_access is low.
- Satisfaction terms:
  - i_ok = (I_WAIT & imem_resp_i & ~flush_i) | I_DONE
  - d_ok = ~mem_access | dmem_resp_i | D_DONE
  - advance = i_ok & d_ok
- Combinational outputs:
  - dmem_stall_o = ~d_ok
  - imem_stall_o = ~i_ok & ~flush_i
  - imem_read_o = (state == I_WAIT)
- D-stall (dmem_stall_o=1): ld_o = 0 on all bits; pc_ld_o = 0; bubble_o = 0. The D-stall has priority over the I-stall and over flush.
- I-only stall with SPLIT_STALL=1: ld_o[0]=0; ld_o[NUM_REGS-1:1] all 1; bubble_o=1; pc_ld_o=0.
- I-only stall with SPLIT_STALL=0: all ld_o bits 0; bubble_o=0.
- Advance: all ld_o bits 1; pc_ld_o=1; bubble_o=0.
- Flush without a D-stall: pc_ld_o=1; ld_o[0]=1 (the IF_ID clear is done by the flush path elsewhere).
- Latency: zero-cycle, combinational from resp to ld_o. A response captured in a DONE state releases the stall in the cycle the other port completes.
- stall_cycles_o: increments on cycles with advance=0 and no flush; saturates at all-ones with no wrap.
- Reset, including mid-miss: FSMs go to I_WAIT/D_IDLE and the counter to 0. While rst=1, ld_o=0, pc_ld_o=0, bubble_o=0 and imem_read_o=0 regardless of inputs.
- Simultaneous responses on both ports: advance in the same cycle; no DONE state is entered.
- A response arriving while the FSM is in a DONE state is illegal. The bench asserts it never happens.

Decomposition:
- rv32i_types already provides rv32i_control_word, op_load and op_store.
- Add to rv32i_types: imem_state_t {I_WAIT, I_DONE, I_DROP} and dmem_state_t {D_IDLE, D_DONE}.
- One sub-module, sat_counter (parameter W; inputs inc, clr), instantiated for stall_cycles_o.

Test Plan:
- No data access, imem_resp_i every cycle -> ld_o=4'b1111, pc_ld_o=1 every cycle, stall_cycles_o stays 0.
- op_load; imem_resp_i at cycle 2, dmem_resp_i at cycle 5 -> I_DONE in cycles 3-5, all ld_o=0 in cycles 2-4, all 1 in cycle 5, stall_cycles_o=3.
- No data access, imem_resp_i delayed 3 cycles, SPLIT_STALL=1 -> ld_o=4'b1110 and bubble_o=1 for 3 cycles. Repeat with SPLIT_STALL=0 -> ld_o=4'b0000 and bubble_o=0 for the same 3 cycles.
- flush_i during I_WAIT, stale resp 2 cycles later -> I_DROP for 2 cycles with imem_read_o=0; the stale resp causes no ld_o[0]; back to I_WAIT.
- op_store with imem_resp_i and dmem_resp_i in the same cycle -> single-cycle advance; no DONE state entered.
- rst asserted mid D-stall with the counter at 0xFFFE -> outputs zero immediately and the counter is 0. A separate run driving 0x1_0000 stall cycles -> stall_cycles_o=16'hFFFF (saturated).
